// File: rtl/sha1_pad.sv
`default_nettype none
// ============================================================================
//  Module      : sha1_pad
//  Description : SHA-1 message padder; packs 32-bit words into 512-bit blocks
//                and appends the 0x80 marker, zero fill and 64-bit length.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha1_pad (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         in_ready,
    output logic         blk_valid,
    output logic [511:0] blk_data,
    output logic         blk_last,
    input  logic         blk_done
);

    localparam logic [1:0] C_FILL  = 2'd0;
    localparam logic [1:0] C_SEND  = 2'd1;
    localparam logic [1:0] C_EXTRA = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [3:0]   r_k;
    logic [63:0]  r_len;
    logic [511:0] r_blk;
    logic         r_last;
    logic         r_extra;
    logic         r_extra_pad;

    logic         w_accept;
    logic [2:0]   w_nb;
    logic         w_n4;
    logic         w_fits;
    logic [5:0]   w_shift;
    logic [63:0]  w_len_nxt;
    logic [31:0]  w_word;
    logic [511:0] w_fill_blk;
    logic [511:0] w_extra_blk;

    assign w_accept  = in_valid && (r_state == C_FILL);
    assign w_nb      = (!in_last || (in_nbytes > 3'd4)) ? 3'd4 : in_nbytes;
    assign w_n4      = (w_nb == 3'd4);
    assign w_fits    = w_n4 ? (r_k <= 4'd12) : (r_k <= 4'd13);
    assign w_shift   = {w_nb, 3'b000};
    assign w_len_nxt = r_len + {58'd0, w_nb, 3'b000};

    // A shift of 32 yields all-ones keep and no marker, so n=4 passes through.
    assign w_word = in_last ? ((in_data & ~(32'hFFFF_FFFF >> w_shift)) |
                               (32'h8000_0000 >> w_shift))
                            : in_data;

    always_comb begin
        w_fill_blk = r_blk;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) == r_k) begin
                w_fill_blk[511-32*i -: 32] = w_word;
            end else if (in_last && (4'(i) > r_k)) begin
                w_fill_blk[511-32*i -: 32] =
                    (w_n4 && (4'(i) == r_k + 4'd1)) ? 32'h8000_0000 : 32'h0;
            end
        end
        if (in_last && w_fits) begin
            w_fill_blk[63:0] = w_len_nxt;
        end
    end

    always_comb begin
        w_extra_blk          = '0;
        w_extra_blk[511:480] = r_extra_pad ? 32'h8000_0000 : 32'h0;
        w_extra_blk[63:0]    = r_len;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_FILL:  if (w_accept && (in_last || (r_k == 4'd15))) w_state_nxt = C_SEND;
            C_SEND:  if (blk_done) w_state_nxt = r_extra ? C_EXTRA : C_FILL;
            C_EXTRA: w_state_nxt = C_SEND;
            default: w_state_nxt = C_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k         <= '0;
            r_len       <= '0;
            r_blk       <= '0;
            r_last      <= 1'b0;
            r_extra     <= 1'b0;
            r_extra_pad <= 1'b0;
        end else begin
            case (r_state)
                C_FILL: begin
                    if (w_accept) begin
                        r_blk <= w_fill_blk;
                        r_len <= w_len_nxt;
                        if (in_last) begin
                            r_last      <= w_fits;
                            r_extra     <= !w_fits;
                            r_extra_pad <= w_n4 && (r_k == 4'd15);
                        end else begin
                            // Wraps 15 -> 0 when a full block leaves for SEND.
                            r_k    <= r_k + 4'd1;
                            r_last <= 1'b0;
                        end
                    end
                end
                C_SEND: begin
                    if (blk_done && !r_extra && r_last) begin
                        r_len  <= '0;
                        r_k    <= '0;
                        r_last <= 1'b0;
                    end
                end
                C_EXTRA: begin
                    r_blk   <= w_extra_blk;
                    r_last  <= 1'b1;
                    r_extra <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == C_FILL);
    assign blk_valid = (r_state == C_SEND);
    assign blk_last  = r_last;
    assign blk_data  = r_blk;

endmodule
`default_nettype wire

// File: tb/tb_sha1_pad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha1_pad
//  Description : Randomised bench for sha1_pad against a byte-level padding model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha1_pad;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [2:0]   in_nbytes = '0;
    logic         in_ready;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         blk_done = 1'b0;

    sha1_pad u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .in_ready  (in_ready),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .blk_done  (blk_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  msg_w[$];
    logic [2:0]   msg_nb;
    logic [511:0] exp_blk[$];

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Textbook SHA-1 padding over the message as a flat byte string.
    function automatic void build_expected();
        logic [7:0]   b[$];
        logic [63:0]  bits;
        logic [511:0] v;
        int           neff;
        neff = (msg_nb > 3'd4) ? 4 : int'(msg_nb);
        exp_blk.delete();
        for (int w = 0; w < msg_w.size(); w++) begin
            int cnt;
            logic [31:0] word;
            cnt  = (w == msg_w.size() - 1) ? neff : 4;
            word = msg_w[w];
            for (int j = 0; j < cnt; j++) b.push_back(word[31-8*j -: 8]);
        end
        bits = 64'(b.size()) * 64'd8;
        b.push_back(8'h80);
        while ((b.size() % 64) != 56) b.push_back(8'h00);
        for (int j = 7; j >= 0; j--) b.push_back(bits[8*j +: 8]);
        for (int k = 0; k < b.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) v[511-8*j -: 8] = b[64*k + j];
            exp_blk.push_back(v);
        end
    endfunction

    task automatic drive_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
        int t;
        t = 0;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        while (!in_ready) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_last   = 1'($urandom_range(0, 1));
            in_nbytes = 3'($urandom_range(0, 7));
            @(negedge clk);
            t++;
            if (t > 2000) begin
                check_eq("in_ready_timeout", 512'(in_ready), 512'd1);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        in_nbytes = nb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drive_msg();
        for (int w = 0; w < msg_w.size(); w++) begin
            if (w == msg_w.size() - 1) drive_word(msg_w[w], 1'b1, msg_nb);
            else                       drive_word(msg_w[w], 1'b0, 3'($urandom_range(0, 7)));
        end
    endtask

    // Returns 1 if a block appeared within the budget.
    task automatic wait_blk(output bit ok);
        int t;
        t  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!blk_valid) begin
            blk_done = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            t++;
            if (t > 3000) begin
                blk_done = 1'b0;
                check_eq("blk_valid_timeout", 512'(blk_valid), 512'd1);
                ok = 1'b0;
                return;
            end
        end
        blk_done = 1'b0;
    endtask

    task automatic consume(input int hold_max);
        bit ok;
        for (int b = 0; b < exp_blk.size(); b++) begin
            bit lst;
            lst = (b == exp_blk.size() - 1);
            wait_blk(ok);
            if (!ok) return;
            check_eq($sformatf("blk%0d_data", b), blk_data, exp_blk[b]);
            check_eq($sformatf("blk%0d_last", b), 512'(blk_last), 512'(lst));
            repeat ($urandom_range(0, hold_max)) @(negedge clk);
            check_eq($sformatf("blk%0d_hold", b), blk_data, exp_blk[b]);
            blk_done = 1'b1;
            @(posedge clk);
            #1;
            blk_done = 1'b0;
            @(negedge clk);
            check_eq("valid_drop", 512'(blk_valid), 512'd0);
            if (lst) check_eq("ready_rise", 512'(in_ready), 512'd1);
        end
    endtask

    task automatic run_msg(input int hold_max);
        build_expected();
        fork
            drive_msg();
            consume(hold_max);
        join
    endtask

    task automatic rand_msg(input int nwords, input logic [2:0] nb);
        msg_w.delete();
        for (int i = 0; i < nwords; i++) msg_w.push_back($urandom);
        msg_nb = nb;
    endtask

    task automatic backpressure();
        bit ok;
        msg_w.delete();
        msg_w.push_back($urandom);
        msg_nb = 3'd2;
        build_expected();
        drive_msg();
        wait_blk(ok);
        if (!ok) return;
        for (int c = 0; c < 100; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_last   = 1'($urandom_range(0, 1));
            in_nbytes = 3'($urandom_range(0, 7));
            @(negedge clk);
            check_eq("bp_valid", 512'(blk_valid), 512'd1);
            check_eq("bp_data", blk_data, exp_blk[0]);
            check_eq("bp_ready", 512'(in_ready), 512'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        blk_done = 1'b1;
        @(posedge clk);
        #1;
        blk_done = 1'b0;
        @(negedge clk);
        check_eq("bp_drop", 512'(blk_valid), 512'd0);
        check_eq("bp_ready_rise", 512'(in_ready), 512'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 512'(blk_valid), 512'd0);
        check_eq("rst_last", 512'(blk_last), 512'd0);
        check_eq("rst_data", blk_data, 512'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 512'(in_ready), 512'd1);

        // "abc"
        msg_w.delete();
        msg_w.push_back(32'h6162_6300);
        msg_nb = 3'd3;
        exp_blk.delete();
        exp_blk.push_back({32'h6162_6380, 448'd0, 32'h0000_0018});
        fork drive_msg(); consume(3); join

        // Empty message with junk in the word
        msg_w.delete();
        msg_w.push_back(32'hDEAD_BEEF);
        msg_nb = 3'd0;
        exp_blk.delete();
        exp_blk.push_back({32'h8000_0000, 480'd0});
        fork drive_msg(); consume(3); join

        rand_msg(14, 3'd4); run_msg(3);  // 56 bytes
        rand_msg(16, 3'd4); run_msg(3);  // 64 bytes
        rand_msg(14, 3'd3); run_msg(3);  // 55 bytes
        rand_msg(15, 3'd4); run_msg(3);  // 60 bytes
        rand_msg(16, 3'd0); run_msg(3);  // 60 bytes, empty last word
        rand_msg(13, 3'd6); run_msg(3);  // nbytes > 4

        for (int r = 0; r < 25; r++) begin
            rand_msg($urandom_range(1, 40), 3'($urandom_range(0, 7)));
            run_msg(5);
        end

        backpressure();

        // Reset while block 1 of a 56-byte message is being presented
        rand_msg(14, 3'd4);
        drive_msg();
        wait_blk(ok);
        rst_n = 1'b0;
        #1;
        check_eq("rstsend_valid", 512'(blk_valid), 512'd0);
        check_eq("rstsend_data", blk_data, 512'd0);
        check_eq("rstsend_last", 512'(blk_last), 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("rstsend_quiet", 512'(blk_valid), 512'd0);
        end
        check_eq("rstsend_ready", 512'(in_ready), 512'd1);

        msg_w.delete();
        msg_w.push_back(32'h6162_6300);
        msg_nb = 3'd3;
        exp_blk.delete();
        exp_blk.push_back({32'h6162_6380, 448'd0, 32'h0000_0018});
        fork drive_msg(); consume(3); join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha1_pad.md
SHA1_PAD -- requirements
Module: sha1_pad

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset; ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  message word present on in_data.
REQ-005 in_data  input  32  message word, big-endian (byte 0 = in_data[31:24]).
REQ-006 in_last  input  1  in_data is the final word of the message.
REQ-007 in_nbytes  input  3  valid bytes in the final word, 0..4; values >4 SHALL be treated as 4; ignored when in_last=0 (word counts as 4 bytes).
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 blk_valid  output  1  padded 512-bit block presented to the compression controller.
REQ-010 blk_data  output  512  block; word 0 = blk_data[511:480], word 15 = blk_data[31:0].
REQ-011 blk_last  output  1  block is the final block of the message (qualified by blk_valid).
REQ-012 blk_done  input  1  one-cycle pulse from the compression controller when its 80-round pass on the current block completes.

Function
REQ-013 States SHALL be FILL, SEND and EXTRA; reset state FILL.
REQ-014 A word SHALL be accepted when in_valid=1 and in_ready=1; in_ready SHALL be 1 only in FILL.
REQ-015 Accepted words SHALL be written to buffer word index k (0..15), then k increments; the 64-bit bit-length counter SHALL add 32 (non-last) or 8*n (last), wrapping mod 2^64.
REQ-016 Non-last word accepted at k=15: next cycle SEND with blk_last=0, k cleared.
REQ-017 Last word at index k, n<4: byte n of word k SHALL be 0x80, remaining bytes of word k and words k+1..15 SHALL be 0.
REQ-018 Last word at k, n=4: word k+1 SHALL be 0x80000000 when k<=14, other trailing words 0.
REQ-019 Length fits when (n<4 and k<=13) or (n=4 and k<=12): words 14,15 SHALL hold the final bit count (word 14 = high 32 bits), blk_last=1, next cycle SEND.
REQ-020 Otherwise: first block sent with blk_last=0, then extra block required.
REQ-021 In SEND, blk_valid=1 and blk_data stable until blk_done; blk_done while blk_valid=0 SHALL be ignored.
REQ-022 On blk_done in SEND: if extra block pending, go EXTRA; else go FILL, and if blk_last=1 clear bit-length counter and k.
REQ-023 EXTRA SHALL last exactly one cycle: build block of zeros, word 0 = 0x80000000 only if the final word was n=4 at k=15, words 14,15 = bit count; then SEND with blk_last=1.
REQ-024 blk_valid SHALL drop and in_ready SHALL rise the cycle after blk_done (when returning to FILL).
REQ-025 Inputs on in_* while in_ready=0 SHALL have no effect.

Reset
REQ-026 On rst_n=0, immediately: state FILL, k=0, bit count=0, blk_valid=0, blk_last=0, blk_data=0, in_ready=1 after reset release; pending extra-block flag cleared.
REQ-027 Reset mid-SEND or mid-EXTRA SHALL abandon the message with no further blk_valid.

Verification
REQ-028 "abc": one word 0x61626300, in_last=1, n=3 -> one block, word0=0x61626380, words1..14=0, word15=0x00000018, blk_last=1.
REQ-029 Empty message: word k=0, in_last=1, n=0 -> word0=0x80000000, words1..15=0, blk_last=1.
REQ-030 56 bytes (14 words, last n=4) -> block1 blk_last=0, word14=0x80000000, word15=0; after blk_done block2 words0..13=0, word15=0x000001C0, blk_last=1.
REQ-031 64 bytes (16 words, last n=4) -> block1 raw data blk_last=0; block2 word0=0x80000000, word15=0x00000200, blk_last=1.
REQ-032 Backpressure: blk_done withheld 100 cycles -> blk_valid and blk_data stable, in_ready=0, in_valid pulses ignored.
REQ-033 rst_n asserted during SEND of block1 of the 56-byte case -> blk_valid=0 immediately; next "abc" message produces exact REQ-028 block.
